toggle_decoder: RTL
===================

TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter CNT_W, default 4, SHALL set the pending-event counter width.
REQ-003 Port clock, input, 1, SHALL be the sole clock; all flops SHALL update on its falling edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-005 Port Q_in, input, 1, SHALL be the toggle line; each level change encodes one event.
REQ-006 Port read, input, 1, SHALL be the consumer pop request for one pending event.
REQ-007 Port clear, input, 1, SHALL be the synchronous flush of pending count and overflow.
REQ-008 Port event_pulse, output, 1, SHALL flag a toggle detected at the most recent edge.
REQ-009 Port valid, output, 1, SHALL be high whenever pending > 0.
REQ-010 Port pending, output, CNT_W, SHALL be the number of unread events.
REQ-011 Port overflow, output, 1, SHALL be a sticky flag for an event lost at saturation.

Function
REQ-012 States SHALL be INIT and RUN; reset SHALL force INIT.
REQ-013 INIT: the first falling edge after reset release SHALL capture Q_in (post-sync) into ref, generate no event, and go to RUN.
REQ-014 RUN: at each falling edge where sampled Q_in != ref, ref SHALL take Q_in, and event_pulse SHALL be high for exactly that following clock period.
REQ-015 Detection latency (Q_in change to event_pulse high) SHALL be one falling edge with no sync stage.
REQ-016 Toggle with no accepted read: pending SHALL increment by 1.
REQ-017 Read with valid=1 and no toggle: pending SHALL decrement by 1.
REQ-018 Toggle and accepted read at the same edge: pending SHALL be unchanged; event_pulse SHALL still assert.
REQ-019 Read while valid=0 SHALL be ignored; pending SHALL never wrap below 0.
REQ-020 Toggle while pending = 2^CNT_W-1 and no read: pending SHALL hold; overflow SHALL set.
REQ-021 overflow SHALL stay set until clear or reset.
REQ-022 clear SHALL set pending=0 and overflow=0 at that edge and SHALL discard any read.
REQ-023 clear coincident with a toggle SHALL leave pending=1 and event_pulse high; ref SHALL update.
REQ-024 clear in INIT SHALL have no effect beyond zeroing pending and overflow.
REQ-025 Q_in toggling twice between two edges SHALL be undetectable and SHALL NOT be flagged (a documented limitation).

Reset
REQ-026 Asserting reset SHALL immediately force INIT, ref=0, event_pulse=0, pending=0, valid=0, overflow=0, and any sync flops=0.
REQ-027 Reset asserted mid-operation SHALL discard all pending events; no event SHALL be reported for the Q_in level seen at release.

Configuration
REQ-028 Macro TOGGLE_DECODER_SYNC_EN defined SHALL insert a two-flop falling-edge synchronizer on Q_in before detection, raising detection latency to three falling edges and delaying INIT capture by two edges.
REQ-029 Without TOGGLE_DECODER_SYNC_EN, Q_in SHALL feed detection directly with one-edge latency.

Verification
REQ-030 Q_in=1 held through reset release, then constant -> after INIT no event_pulse; pending=0, valid=0.
REQ-031 Three single toggles of Q_in on separate cycles, read=0 -> three one-cycle event_pulses; pending=3, valid=1.
REQ-032 pending=2, toggle plus read at the same edge -> pending stays 2; next read alone -> pending=1.
REQ-033 CNT_W=4, 16 toggles with no read -> pending=15, overflow=1; a read then gives 14, overflow still 1; clear gives 0 and 0.
REQ-034 pending=5, reset pulsed mid-cycle -> all outputs 0 immediately, with no event after release.
REQ-035 With TOGGLE_DECODER_SYNC_EN, a single Q_in toggle -> event_pulse on the third falling edge; pending=1.

Source files
------------

// File: rtl/toggle_decoder.sv
// Toggle-line event decoder: each level change on Q_in becomes one pending event.
// Define TOGGLE_DECODER_SYNC_EN to add a two-flop falling-edge synchronizer on Q_in.
module toggle_decoder #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Q_in,
    input  logic             read,
    input  logic             clear,
    output logic             event_pulse,
    output logic             valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             ref_q;
    logic             q_det;
    logic             init_go;
    logic             toggle;
    logic             take;
    logic [CNT_W-1:0] pend_next;
    logic             ovf_next;

`ifdef TOGGLE_DECODER_SYNC_EN
    logic       sync1;
    logic       sync2;
    logic [1:0] warm;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Q_in;
            sync2 <= sync1;
        end
    end

    // INIT waits until the synchronizer holds a real sample before capturing ref.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            warm <= 2'd0;
        end else if (state == INIT && warm != 2'd2) begin
            warm <= warm + 2'd1;
        end
    end

    assign q_det   = sync2;
    assign init_go = (warm == 2'd2);
`else
    assign q_det   = Q_in;
    assign init_go = 1'b1;
`endif

    assign toggle = (state == RUN) && (q_det != ref_q);
    assign take   = read && valid && !clear;

    // Saturating pending counter; a toggle lost at saturation sets the sticky overflow.
    always_comb begin
        pend_next = pending;
        ovf_next  = overflow;
        if (clear) begin
            pend_next = toggle ? CNT_ONE : '0;
            ovf_next  = 1'b0;
        end else if (toggle && !take) begin
            if (pending == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = pending + CNT_ONE;
            end
        end else if (!toggle && take) begin
            pend_next = pending - CNT_ONE;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state       <= INIT;
            ref_q       <= 1'b0;
            event_pulse <= 1'b0;
            pending     <= '0;
            valid       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pending     <= pend_next;
            valid       <= (pend_next != '0);
            overflow    <= ovf_next;
            event_pulse <= toggle;
            case (state)
                INIT: begin
                    if (init_go) begin
                        ref_q <= q_det;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (toggle) begin
                        ref_q <= q_det;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
